terrain_generator: RTL and testbench

Generates the random ground profile for the tank game, paints it to the frame buffer, then serves column-height lookups. Sits upstream of the game FSM. It replaces the hard-coded 160x8 ground RAM initialisation and supplies `ground_height_at_x`. It drives the VGA adapter's x/y/colour/plot inputs only while busy; the top level muxes those inputs to the game FSM once `done` is high.

---
 rtl/terrain_pkg.sv | 25 ++
 rtl/terrain_lfsr.sv | 29 ++
 rtl/terrain_generator.sv | 230 +++++++++++++++++++++++
 tb/tb_terrain_generator.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/terrain_pkg.sv
// Shared types and constants for the terrain generator.
// TERRAIN_SMOOTH_EN adds the SMOOTH state to the controller.
package terrain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
`ifdef TERRAIN_SMOOTH_EN
        SMOOTH,
`endif
        DRAW,
        READY
    } state_t;

    localparam logic [2:0] GROUND    = 3'b010;
    localparam logic [2:0] SKY       = 3'b000;
    localparam logic [7:0] LFSR_MASK = 8'hB8;
    localparam logic [7:0] NO_GROUND = 8'd120;

    // Right-shifting Galois step; a non-zero state never reaches zero.
    function automatic logic [7:0] lfsr_advance(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/terrain_lfsr.sv
// 8-bit Galois LFSR with synchronous load and step; a zero seed is
// replaced by SEED so the register can never lock up.
module terrain_lfsr
    import terrain_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] next_value
);

    logic [7:0] value;

    assign next_value = lfsr_advance(value);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            value <= SEED;
        else if (load)
            value <= (seed == '0) ? SEED : seed;
        else if (step)
            value <= next_value;
    end

endmodule

// File: rtl/terrain_generator.sv
// Random ground profile: generate heights, paint them column-major, then
// serve registered height lookups. TERRAIN_SMOOTH_EN enables a 1-2-1 smoothing pass.
module terrain_generator
    import terrain_pkg::*;
#(
    parameter int         WIDTH  = 160,
    parameter int         HEIGHT = int'(NO_GROUND),
    parameter int         MIN_H  = 60,
    parameter int         MAX_H  = 115,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] seed,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    input  logic [7:0] q_x,
    output logic [7:0] q_h,
    output logic       q_valid
);

    localparam logic [7:0] LAST_COL = 8'(WIDTH - 1);
    localparam logic [7:0] LAST_ROW = 8'(HEIGHT - 1);
    localparam logic [7:0] NUM_COL  = 8'(WIDTH);
    localparam logic [7:0] NO_GND   = 8'(HEIGHT);
    localparam logic [7:0] LO_H     = 8'(MIN_H);
    localparam logic [7:0] HI_H     = 8'(MAX_H);
    localparam logic [7:0] MID_H    = 8'((MIN_H + MAX_H) >> 1);

    state_t state, state_n;
    logic [7:0] col, col_n, row, row_n;
    logic       bub, bub_n;
    logic       lfsr_load, lfsr_step_en;
    logic [7:0] lfsr_next;
    logic       we, rd_en;
    logic [7:0] waddr, wdata, rd_addr, rd_q;
    logic [7:0] prev_h, gen_h;
    logic signed [8:0] gen_sum;
    logic [7:0] x_n, y_n;
    logic [2:0] colour_n;
    logic       plot_n;
    logic [7:0] mem [WIDTH];
    logic [7:0] q_raw;
    logic       q_in, q_hit, q_live;

    terrain_lfsr #(.SEED(SEED)) u_lfsr (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .load       (lfsr_load),
        .seed       (seed),
        .step       (lfsr_step_en),
        .next_value (lfsr_next)
    );

    always_comb begin
        case (lfsr_next[1:0])
            2'b00:   gen_sum = $signed({1'b0, prev_h}) - 9'sd1;
            2'b11:   gen_sum = $signed({1'b0, prev_h}) + 9'sd1;
            default: gen_sum = $signed({1'b0, prev_h});
        endcase
        if (col == '0)
            gen_h = MID_H;
        else if (gen_sum < $signed({1'b0, LO_H}))
            gen_h = LO_H;
        else if (gen_sum > $signed({1'b0, HI_H}))
            gen_h = HI_H;
        else
            gen_h = gen_sum[7:0];
    end

`ifdef TERRAIN_SMOOTH_EN
    localparam logic [7:0] SMOOTH_LAST = 8'(WIDTH + 1);
    logic [7:0] sw_a, sw_b, sm_h;
    logic [9:0] sm_sum;

    // Window (sw_a, sw_b, rd_q) = h[i-1], h[i], h[i+1] while writing column col-2;
    // reads run two columns ahead of writes, so only original heights are read.
    assign sm_sum = {2'b00, sw_a} + {1'b0, sw_b, 1'b0} + {2'b00, rd_q};
    assign sm_h   = 8'(sm_sum >> 2);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sw_a <= '0;
            sw_b <= '0;
        end else if (state == SMOOTH) begin
            sw_a <= (col == 8'd1) ? rd_q : sw_b;
            sw_b <= rd_q;
        end
    end
`endif

    always_comb begin
        state_n      = state;
        col_n        = col;
        row_n        = row;
        bub_n        = bub;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        we           = 1'b0;
        waddr        = col;
        wdata        = gen_h;
        rd_en        = 1'b0;
        rd_addr      = col;
        case (state)
            IDLE, READY: begin
                if (start) begin
                    state_n   = GEN;
                    col_n     = '0;
                    lfsr_load = 1'b1;
                end
            end
            GEN: begin
                lfsr_step_en = 1'b1;
                we           = 1'b1;
                col_n        = col + 8'd1;
                if (col == LAST_COL) begin
                    col_n = '0;
`ifdef TERRAIN_SMOOTH_EN
                    state_n = SMOOTH;
`else
                    state_n = DRAW;
                    row_n   = '0;
                    bub_n   = 1'b1;
`endif
                end
            end
`ifdef TERRAIN_SMOOTH_EN
            SMOOTH: begin
                rd_en   = 1'b1;
                rd_addr = (col < LAST_COL) ? col : LAST_COL;
                we      = (col >= 8'd2);
                waddr   = col - 8'd2;
                wdata   = sm_h;
                col_n   = col + 8'd1;
                if (col == SMOOTH_LAST) begin
                    state_n = DRAW;
                    col_n   = '0;
                    row_n   = '0;
                    bub_n   = 1'b1;
                end
            end
`endif
            DRAW: begin
                if (bub) begin
                    bub_n = 1'b0;
                    row_n = '0;
                end else if (row == LAST_ROW) begin
                    row_n = '0;
                    if (col == LAST_COL) begin
                        state_n = READY;
                        col_n   = '0;
                    end else begin
                        col_n = col + 8'd1;
                        bub_n = 1'b1;
                    end
                end else begin
                    row_n = row + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Entering a bubble cycle fetches that column's height for its pixels.
        if (state_n == DRAW && bub_n) begin
            rd_en   = 1'b1;
            rd_addr = col_n;
        end

        plot_n   = (state_n == DRAW) && !bub_n;
        x_n      = (state_n == DRAW) ? col_n : '0;
        y_n      = plot_n ? row_n : '0;
        colour_n = (plot_n && row_n >= rd_q) ? GROUND : SKY;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            bub    <= 1'b0;
            prev_h <= '0;
            x      <= '0;
            y      <= '0;
            colour <= SKY;
            plot   <= 1'b0;
        end else begin
            state  <= state_n;
            col    <= col_n;
            row    <= row_n;
            bub    <= bub_n;
            if (state == GEN)
                prev_h <= gen_h;
            x      <= x_n;
            y      <= y_n;
            colour <= colour_n;
            plot   <= plot_n;
        end
    end

    assign q_in = (q_x < NUM_COL);

    always_ff @(posedge CLOCK_50) begin
        if (we)
            mem[waddr] <= wdata;
        if (rd_en)
            rd_q <= mem[rd_addr];
        q_raw <= mem[q_in ? q_x : 8'd0];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            q_live <= 1'b0;
            q_hit  <= 1'b0;
        end else begin
            q_live <= (state == READY);
            q_hit  <= q_in;
        end
    end

    assign q_valid = q_live;
    assign q_h     = (q_live && q_hit) ? q_raw : NO_GND;
    assign busy    = (state != IDLE) && (state != READY);
    assign done    = (state == READY);

endmodule

// File: tb/tb_terrain_generator.sv
// Directed bench for terrain_generator: default instance plus a flat-ground
// instance (MIN_H = MAX_H = 87).
module tb_terrain_generator;

    localparam int W = 160;
    localparam int H = 120;
`ifdef TERRAIN_SMOOTH_EN
    localparam int DONE_LAT = 19683;
`else
    localparam int DONE_LAT = 19521;
`endif
    localparam int DRAW_START = DONE_LAT - W * (H + 1);

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed_m = 8'h00, seed_f = 8'h00, q_x = 8'h00;
    logic       busy_m, done_m, plot_m, q_valid_m;
    logic [7:0] x_m, y_m, q_h_m;
    logic [2:0] colour_m;
    logic       busy_f, done_f, plot_f, q_valid_f;
    logic [7:0] x_f, y_f, q_h_f;
    logic [2:0] colour_f;

    int errors = 0;
    int checks = 0;
    int model_h [W];
    int obs_h [W];

    always #10 CLOCK_50 = ~CLOCK_50;

    terrain_generator dut (
        .CLOCK_50 (CLOCK_50), .resetn (resetn), .start (start), .seed (seed_m),
        .busy (busy_m), .done (done_m), .x (x_m), .y (y_m), .colour (colour_m),
        .plot (plot_m), .q_x (q_x), .q_h (q_h_m), .q_valid (q_valid_m)
    );

    terrain_generator #(.MIN_H(87), .MAX_H(87)) dut_flat (
        .CLOCK_50 (CLOCK_50), .resetn (resetn), .start (start), .seed (seed_f),
        .busy (busy_f), .done (done_f), .x (x_f), .y (y_f), .colour (colour_f),
        .plot (plot_f), .q_x (q_x), .q_h (q_h_f), .q_valid (q_valid_f)
    );

    // Reference profile for the default MIN_H/MAX_H.
    task automatic build_model(input logic [7:0] sd);
        logic [7:0] s;
        int h, d, l, r;
        int tmp [W];
        s = (sd == 8'h00) ? 8'hA5 : sd;
        h = 0;
        for (int i = 0; i < W; i++) begin
            s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
            if (i == 0) h = (60 + 115) / 2;
            else begin
                case (s[1:0])
                    2'b00:   d = -1;
                    2'b11:   d = 1;
                    default: d = 0;
                endcase
                h = h + d;
                if (h < 60) h = 60;
                if (h > 115) h = 115;
            end
            model_h[i] = h;
        end
        tmp = model_h;
`ifdef TERRAIN_SMOOTH_EN
        for (int i = 0; i < W; i++) begin
            l = (i == 0) ? tmp[0] : tmp[i-1];
            r = (i == W - 1) ? tmp[W-1] : tmp[i+1];
            model_h[i] = (l + 2 * tmp[i] + r) / 4;
        end
`endif
    endtask

    task automatic test_reset();
        #3 resetn = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if ({busy_m, done_m, plot_m, q_valid_m} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000", {busy_m, done_m, plot_m, q_valid_m});
        end
        checks++;
        if ({x_m, y_m, colour_m} !== 19'd0) begin
            errors++;
            $display("FAIL reset_pixel got x=%0d y=%0d c=%b want 0/0/000", x_m, y_m, colour_m);
        end
        checks++;
        if (q_h_m !== 8'd120) begin
            errors++;
            $display("FAIL reset_q_h got=%0d want=120", q_h_m);
        end
        checks++;
        if ({busy_f, done_f, plot_f, q_h_f} !== {3'b000, 8'd120}) begin
            errors++;
            $display("FAIL reset_flat got=%b/%0d want 000/120", {busy_f, done_f, plot_f}, q_h_f);
        end
        @(negedge CLOCK_50) resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({busy_m, done_m} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_start got busy/done=%b want=00", {busy_m, done_m});
        end
    endtask

    task automatic test_generate();
        int cyc, ecol, erow, exp_cyc, bad_pix, n_plot, green_f, qv_bad;
        logic [2:0] exp_c, px86, px87;
        build_model(8'h00);
        cyc = 0; ecol = 0; erow = 0; bad_pix = 0; n_plot = 0; green_f = 0; qv_bad = 0;
        px86 = 3'bxxx; px87 = 3'bxxx;
        @(negedge CLOCK_50);
        seed_m = 8'h00; seed_f = 8'h3C; start = 1'b1;
        while (done_m !== 1'b1 && cyc < DONE_LAT + 100) begin
            @(negedge CLOCK_50);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                checks++;
                if ({busy_m, done_m} !== 2'b10) begin
                    errors++;
                    $display("FAIL busy_after_start got busy/done=%b want=10", {busy_m, done_m});
                end
            end
            if (q_valid_m !== 1'b0 && done_m !== 1'b1) qv_bad++;
            if (plot_m === 1'b1) begin
                if (ecol >= W) bad_pix++;
                else begin
                    exp_cyc = DRAW_START + ecol * (H + 1) + 1 + erow;
                    exp_c = (erow >= model_h[ecol]) ? 3'b010 : 3'b000;
                    if (x_m !== 8'(ecol) || y_m !== 8'(erow) || colour_m !== exp_c || cyc != exp_cyc) begin
                        if (bad_pix == 0)
                            $display("pixel detail: cyc=%0d got (%0d,%0d,%b) want cyc=%0d (%0d,%0d,%b)",
                                     cyc, x_m, y_m, colour_m, exp_cyc, ecol, erow, exp_c);
                        bad_pix++;
                    end
                end
                n_plot++;
                erow++;
                if (erow == H) begin erow = 0; ecol++; end
            end
            if (plot_f === 1'b1) begin
                if (colour_f === 3'b010) green_f++;
                if (x_f == 8'd5 && y_f == 8'd86) px86 = colour_f;
                if (x_f == 8'd5 && y_f == 8'd87) px87 = colour_f;
            end
        end
        checks++;
        if (done_m !== 1'b1 || cyc != DONE_LAT) begin
            errors++;
            $display("FAIL done_latency got done=%b at cycle %0d want 1 at %0d", done_m, cyc, DONE_LAT);
        end
        checks++;
        if ({busy_m, plot_m} !== 2'b00) begin
            errors++;
            $display("FAIL ready_outputs got busy/plot=%b want=00", {busy_m, plot_m});
        end
        checks++;
        if (n_plot != W * H) begin
            errors++;
            $display("FAIL plot_count got=%0d want=%0d", n_plot, W * H);
        end
        checks++;
        if (bad_pix != 0) begin
            errors++;
            $display("FAIL pixel_stream got %0d bad pixels want 0", bad_pix);
        end
        checks++;
        if (qv_bad != 0) begin
            errors++;
            $display("FAIL q_valid_busy got %0d cycles high want 0", qv_bad);
        end
        checks++;
        if (done_f !== 1'b1 || green_f != W * 33) begin
            errors++;
            $display("FAIL flat_green got done=%b green=%0d want 1/%0d", done_f, green_f, W * 33);
        end
        checks++;
        if (px86 !== 3'b000 || px87 !== 3'b010) begin
            errors++;
            $display("FAIL flat_pixels got (5,86)=%b (5,87)=%b want 000/010", px86, px87);
        end
    endtask

    task automatic test_lookup();
        int d, maxd;
        @(negedge CLOCK_50) q_x = 8'd10;
        @(negedge CLOCK_50);
        checks++;
        if (q_valid_m !== 1'b1 || q_h_m !== 8'(model_h[10])) begin
            errors++;
            $display("FAIL lookup_10 got v=%b h=%0d want v=1 h=%0d", q_valid_m, q_h_m, model_h[10]);
        end
        q_x = 8'd200;
        @(negedge CLOCK_50);
        checks++;
        if (q_valid_m !== 1'b1 || q_h_m !== 8'd120) begin
            errors++;
            $display("FAIL lookup_oob got v=%b h=%0d want v=1 h=120", q_valid_m, q_h_m);
        end
`ifndef TERRAIN_SMOOTH_EN
        begin
            logic [7:0] cols [4];
            logic [7:0] hts [4];
            cols = '{8'd0, 8'd4, 8'd5, 8'd7};
            hts  = '{8'd87, 8'd86, 8'd85, 8'd86};
            for (int k = 0; k < 4; k++) begin
                q_x = cols[k];
                @(negedge CLOCK_50);
                checks++;
                if (q_h_m !== hts[k]) begin
                    errors++;
                    $display("FAIL lookup_seed_a5 col=%0d got=%0d want=%0d", cols[k], q_h_m, hts[k]);
                end
            end
        end
`endif
        for (int i = 0; i <= W; i++) begin
            @(negedge CLOCK_50);
            if (i > 0) begin
                obs_h[i-1] = q_h_m;
                checks++;
                if (q_h_m !== 8'(model_h[i-1]) || q_h_f !== 8'd87) begin
                    errors++;
                    $display("FAIL lookup_b2b col=%0d got=%0d/%0d want=%0d/87", i - 1, q_h_m, q_h_f, model_h[i-1]);
                end
            end
            if (i < W) q_x = 8'(i);
        end
`ifdef TERRAIN_SMOOTH_EN
        maxd = 0;
        for (int i = 1; i < W; i++) begin
            d = obs_h[i] - obs_h[i-1];
            if (d < 0) d = -d;
            if (d > maxd) maxd = d;
        end
        checks++;
        if (maxd > 1) begin
            errors++;
            $display("FAIL smooth_slope got max step=%0d want<=1", maxd);
        end
`endif
    endtask

    task automatic test_reset_mid_draw();
        int cyc;
        cyc = 0;
        @(negedge CLOCK_50);
        seed_m = 8'h5A; start = 1'b1;
        while (cyc < DRAW_START + 1000) begin
            @(negedge CLOCK_50);
            cyc++;
            if (cyc == 1) start = 1'b0;
        end
        checks++;
        if ({busy_m, plot_m} !== 2'b11) begin
            errors++;
            $display("FAIL mid_draw_precond got busy/plot=%b want=11", {busy_m, plot_m});
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy_m, plot_m, done_m, q_valid_m} !== 4'b0000 || q_h_m !== 8'd120) begin
            errors++;
            $display("FAIL async_abort got b/p/d/v=%b q_h=%0d want 0000/120",
                     {busy_m, plot_m, done_m, q_valid_m}, q_h_m);
        end
        @(negedge CLOCK_50) resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checks++;
        if ({busy_m, done_m} !== 2'b00) begin
            errors++;
            $display("FAIL no_auto_restart got busy/done=%b want=00", {busy_m, done_m});
        end
    endtask

    task automatic test_restart_ignored();
        int cyc, backstep, gap, lastx, mism;
        build_model(8'h5A);
        cyc = 0; backstep = 0; gap = 0; lastx = 0; mism = 0;
        @(negedge CLOCK_50);
        seed_m = 8'h5A; start = 1'b1;
        while (done_m !== 1'b1 && cyc < DONE_LAT + 100) begin
            @(negedge CLOCK_50);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == DRAW_START + 500) begin start = 1'b1; seed_m = 8'h77; end
            if (cyc == DRAW_START + 501) start = 1'b0;
            if (plot_m === 1'b1) begin
                if (int'(x_m) < lastx) backstep++;
                lastx = int'(x_m);
            end
            if (cyc < DONE_LAT && busy_m !== 1'b1) gap++;
        end
        checks++;
        if (done_m !== 1'b1 || cyc != DONE_LAT) begin
            errors++;
            $display("FAIL restart_done_latency got done=%b at %0d want 1 at %0d", done_m, cyc, DONE_LAT);
        end
        checks++;
        if (backstep != 0 || gap != 0 || lastx != W - 1) begin
            errors++;
            $display("FAIL restart_column_order got back=%0d gap=%0d lastx=%0d want 0/0/%0d",
                     backstep, gap, lastx, W - 1);
        end
        for (int i = 0; i <= W; i++) begin
            @(negedge CLOCK_50);
            if (i > 0 && q_h_m !== 8'(model_h[i-1])) mism++;
            if (i < W) q_x = 8'(i);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL regen_profile got %0d differing columns want 0", mism);
        end
    endtask

    initial begin
        test_reset();
        test_generate();
        test_lookup();
        test_reset_mid_draw();
        test_restart_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
